pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control sequencer for a small 16-bit CPU.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, drives the
// datapath strobes and counts retired instructions.
// Optional feature: define PC_SEQ_MEM_WAIT_EN to make FETCH and MEM stall
// until mem_ready_i is high; when undefined, both last exactly one cycle.
module pc_sequencer (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  opcode_i,
  input  logic [2:0]  funct_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  output logic        pc_en_o,
  output logic [1:0]  pc_src_o,
  output logic [2:0]  aluop_o,
  output logic        alu_srca_o,
  output logic [1:0]  alu_srcb_o,
  output logic        ir_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic [2:0]  state_o,
  output logic [15:0] instr_count_o,
  output logic        illegal_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_UNUSED = 3'd7
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_JUMP  = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [2:0]  funct_q, funct_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        retire;
  logic        memDone;
  logic        branchTaken;

`ifdef PC_SEQ_MEM_WAIT_EN
  assign memDone = mem_ready_i;
`else
  logic unusedMemReady;
  assign unusedMemReady = mem_ready_i;
  assign memDone = 1'b1;
`endif

  assign branchTaken = ((opcode_q == OP_BEQ) &&  alu_zero_i) ||
                       ((opcode_q == OP_BNE) && !alu_zero_i);

  // Next-state, opcode latch, retire and datapath strobes; reset forces strobes low
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    retire      = 1'b0;
    pc_en_o     = 1'b0;
    pc_src_o    = 2'b00;
    aluop_o     = 3'b000;
    alu_srca_o  = 1'b0;
    alu_srcb_o  = 2'b00;
    ir_write_o  = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    reg_write_o = 1'b0;
    illegal_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write_o = 1'b1;
        mem_read_o = 1'b1;
        alu_srcb_o = 2'b01;
        pc_en_o    = memDone;
        if (memDone) state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_d   = opcode_i;
        funct_d    = funct_i;
        alu_srcb_o = 2'b11;
        case (opcode_i)
          OP_JUMP: begin
            pc_en_o  = 1'b1;
            pc_src_o = 2'b10;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALTED;
          end
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
            state_d = S_EXEC;
          end
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_srca_o = 1'b1;
        state_d    = S_FETCH;
        case (opcode_q)
          OP_RTYPE: begin
            aluop_o = funct_q;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_srcb_o = 2'b10;
            state_d    = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_srcb_o = 2'b10;
            state_d    = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            aluop_o  = 3'b001;
            pc_en_o  = branchTaken;
            pc_src_o = branchTaken ? 2'b01 : 2'b00;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read_o  = (opcode_q == OP_LW);
        mem_write_o = (opcode_q == OP_SW);
        if (memDone) begin
          if (opcode_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            retire  = (opcode_q == OP_SW);
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (reset_i) begin
      pc_en_o     = 1'b0;
      pc_src_o    = 2'b00;
      aluop_o     = 3'b000;
      alu_srca_o  = 1'b0;
      alu_srcb_o  = 2'b00;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign instr_count_d = instr_count_q + {15'd0, retire};

  // State, latched instruction fields and retired-instruction counter
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      opcode_q      <= 4'd0;
      funct_q       <= 3'd0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct_q       <= funct_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state_o       = state_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [2:0]  funct = 3'd0;
  logic        aluZero = 1'b0;
  logic        memReady = 1'b1;
  logic        pcEn;
  logic [1:0]  pcSrc;
  logic [2:0]  aluop;
  logic        aluSrcA;
  logic [1:0]  aluSrcB;
  logic        irWrite;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic [2:0]  state;
  logic [15:0] instrCount;
  logic        illegal;
  logic [13:0] ctrl;

  int vectorsApplied = 0;
  int miscompares = 0;

  // {pc_en, pc_src, aluop, srca, srcb, ir_write, mem_read, mem_write, reg_write, illegal}
  localparam logic [13:0] C_IDLE   = 14'b0_00_000_0_00_0_0_0_0_0;
  localparam logic [13:0] C_FETCH  = 14'b1_00_000_0_01_1_1_0_0_0;
  localparam logic [13:0] C_FHOLD  = 14'b0_00_000_0_01_1_1_0_0_0;
  localparam logic [13:0] C_DECODE = 14'b0_00_000_0_11_0_0_0_0_0;
  localparam logic [13:0] C_JUMP   = 14'b1_10_000_0_11_0_0_0_0_0;
  localparam logic [13:0] C_ILL    = 14'b0_00_000_0_11_0_0_0_0_1;
  localparam logic [13:0] C_EXR010 = 14'b0_00_010_1_00_0_0_0_0_0;
  localparam logic [13:0] C_EXI    = 14'b0_00_000_1_10_0_0_0_0_0;
  localparam logic [13:0] C_BRT    = 14'b1_01_001_1_00_0_0_0_0_0;
  localparam logic [13:0] C_BRN    = 14'b0_00_001_1_00_0_0_0_0_0;
  localparam logic [13:0] C_MEMLW  = 14'b0_00_000_0_00_0_1_0_0_0;
  localparam logic [13:0] C_MEMSW  = 14'b0_00_000_0_00_0_0_1_0_0;
  localparam logic [13:0] C_WB     = 14'b0_00_000_0_00_0_0_0_1_0;

  assign ctrl = {pcEn, pcSrc, aluop, aluSrcA, aluSrcB, irWrite, memRead, memWrite, regWrite, illegal};

  pc_sequencer dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .start_i       (start),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .alu_zero_i    (aluZero),
    .mem_ready_i   (memReady),
    .pc_en_o       (pcEn),
    .pc_src_o      (pcSrc),
    .aluop_o       (aluop),
    .alu_srca_o    (aluSrcA),
    .alu_srcb_o    (aluSrcB),
    .ir_write_o    (irWrite),
    .mem_read_o    (memRead),
    .mem_write_o   (memWrite),
    .reg_write_o   (regWrite),
    .state_o       (state),
    .instr_count_o (instrCount),
    .illegal_o     (illegal)
  );

  // Free-running 10ns clock
  always #5 clock = ~clock;

  // Reset for two edges, release, pulse START so the next sample sees FETCH
  task automatic applyStimulus;
    reset = 1'b1;
    start = 1'b0;
    memReady = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    opcode = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      vectorsApplied++;
      if (state !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_state[%0d]: got %0d want 0", i, state);
      end
      vectorsApplied++;
      if (ctrl !== C_IDLE || instrCount !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs[%0d]: got ctrl=%b count=%h want ctrl=%b count=0000", i, ctrl, instrCount, C_IDLE);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      vectorsApplied++;
      if (state !== 3'd0 || ctrl !== C_IDLE) begin
        miscompares++;
        $display("[TB] FAIL idle_after_release[%0d]: got state=%0d ctrl=%b want state=0 ctrl=%b", i, state, ctrl, C_IDLE);
      end
    end
  endtask

  task automatic test_rtype;
    int        es[5] = '{1, 2, 3, 5, 1};
    logic [13:0] ec[5] = '{C_FETCH, C_DECODE, C_EXR010, C_WB, C_FETCH};
    int        en[5] = '{0, 0, 0, 0, 1};
    applyStimulus();
    opcode = 4'b0000;
    funct = 3'b010;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectorsApplied++;
      if (state !== 3'(es[i]) || ctrl !== ec[i] || instrCount !== 16'(en[i])) begin
        miscompares++;
        $display("[TB] FAIL rtype[%0d]: got state=%0d ctrl=%b count=%0d want state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instrCount, es[i], ec[i], en[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_branch;
    logic [3:0]  op[4] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101};
    logic        z[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [13:0] ex[4] = '{C_BRT, C_BRN, C_BRN, C_BRT};
    int          es[3] = '{1, 2, 3};
    logic [13:0] ec;
    applyStimulus();
    for (int b = 0; b < 4; b++) begin
      opcode = op[b];
      aluZero = z[b];
      for (int i = 0; i < 3; i++) begin
        #1;
        ec = (i == 0) ? C_FETCH : (i == 1) ? C_DECODE : ex[b];
        vectorsApplied++;
        if (state !== 3'(es[i]) || ctrl !== ec || instrCount !== 16'(b)) begin
          miscompares++;
          $display("[TB] FAIL branch%0d[%0d]: got state=%0d ctrl=%b count=%0d want state=%0d ctrl=%b count=%0d",
                   b, i, state, ctrl, instrCount, es[i], ec, b);
        end
        @(negedge clock);
      end
    end
    #1;
    vectorsApplied++;
    if (state !== 3'd1 || instrCount !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL branch_retire: got state=%0d count=%0d want state=1 count=4", state, instrCount);
    end
  endtask

  task automatic test_memory;
    logic [3:0]  op[10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                            4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000};
    int          es[10] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 1};
    logic [13:0] ec[10] = '{C_FETCH, C_DECODE, C_EXI, C_MEMLW, C_WB,
                            C_FETCH, C_DECODE, C_EXI, C_MEMSW, C_FETCH};
    int          en[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2};
    applyStimulus();
    for (int i = 0; i < 10; i++) begin
      opcode = op[i];
      #1;
      vectorsApplied++;
      if (state !== 3'(es[i]) || ctrl !== ec[i] || instrCount !== 16'(en[i])) begin
        miscompares++;
        $display("[TB] FAIL lw_sw[%0d]: got state=%0d ctrl=%b count=%0d want state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instrCount, es[i], ec[i], en[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_illegal_halt;
    logic [3:0]  op[7] = '{4'b1010, 4'b1010, 4'b1111, 4'b1111, 4'b0110, 4'b0110, 4'b0110};
    int          es[7] = '{1, 2, 1, 2, 6, 6, 6};
    logic [13:0] ec[7] = '{C_FETCH, C_ILL, C_FETCH, C_DECODE, C_IDLE, C_IDLE, C_IDLE};
    int          en[7] = '{0, 0, 0, 0, 1, 1, 1};
    applyStimulus();
    for (int i = 0; i < 7; i++) begin
      opcode = op[i];
      start = (i >= 4);
      #1;
      vectorsApplied++;
      if (state !== 3'(es[i]) || ctrl !== ec[i] || instrCount !== 16'(en[i])) begin
        miscompares++;
        $display("[TB] FAIL illegal_halt[%0d]: got state=%0d ctrl=%b count=%0d want state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instrCount, es[i], ec[i], en[i]);
      end
      @(negedge clock);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    vectorsApplied++;
    if (state !== 3'd0 || instrCount !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL halt_reset: got state=%0d count=%0d want state=0 count=0", state, instrCount);
    end
  endtask

  task automatic test_count_wrap;
    int          es[5] = '{1, 2, 1, 2, 1};
    logic [13:0] ec[5] = '{C_FETCH, C_JUMP, C_FETCH, C_JUMP, C_FETCH};
    logic [15:0] en[5] = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000};
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    force dut.instr_count_q = 16'hFFFE;
    #1;
    release dut.instr_count_q;
    start = 1'b1;
    opcode = 4'b0110;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectorsApplied++;
      if (state !== 3'(es[i]) || ctrl !== ec[i] || instrCount !== en[i]) begin
        miscompares++;
        $display("[TB] FAIL jump_wrap[%0d]: got state=%0d ctrl=%b count=%h want state=%0d ctrl=%b count=%h",
                 i, state, ctrl, instrCount, es[i], ec[i], en[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_in_mem;
    applyStimulus();
    opcode = 4'b0110;
    repeat (2) @(negedge clock);
    opcode = 4'b0010;
    repeat (3) @(negedge clock);
    #1;
    vectorsApplied++;
    if (state !== 3'd4 || ctrl !== C_MEMLW || instrCount !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL reach_mem: got state=%0d ctrl=%b count=%0d want state=4 ctrl=%b count=1", state, ctrl, instrCount, C_MEMLW);
    end
    reset = 1'b1;
    start = 1'b1;
    #1;
    vectorsApplied++;
    if (ctrl !== C_IDLE) begin
      miscompares++;
      $display("[TB] FAIL mem_reset_strobes: got ctrl=%b want %b", ctrl, C_IDLE);
    end
    @(negedge clock);
    #1;
    vectorsApplied++;
    if (state !== 3'd0 || instrCount !== 16'd0 || ctrl !== C_IDLE) begin
      miscompares++;
      $display("[TB] FAIL mem_reset: got state=%0d count=%0d ctrl=%b want state=0 count=0 ctrl=0", state, instrCount, ctrl);
    end
    reset = 1'b0;
    start = 1'b0;
  endtask

`ifdef PC_SEQ_MEM_WAIT_EN
  task automatic test_mem_ready;
    logic        rdy[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          es[10]  = '{1, 1, 2, 3, 4, 4, 4, 4, 5, 1};
    logic [13:0] ec[10]  = '{C_FHOLD, C_FETCH, C_DECODE, C_EXI, C_MEMLW, C_MEMLW, C_MEMLW, C_MEMLW, C_WB, C_FETCH};
    int          en[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    applyStimulus();
    opcode = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      memReady = rdy[i];
      #1;
      vectorsApplied++;
      if (state !== 3'(es[i]) || ctrl !== ec[i] || instrCount !== 16'(en[i])) begin
        miscompares++;
        $display("[TB] FAIL mem_wait[%0d]: got state=%0d ctrl=%b count=%0d want state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instrCount, es[i], ec[i], en[i]);
      end
      @(negedge clock);
    end
    memReady = 1'b1;
  endtask
`else
  task automatic test_mem_ready;
    int          es[6] = '{1, 2, 3, 4, 5, 1};
    logic [13:0] ec[6] = '{C_FETCH, C_DECODE, C_EXI, C_MEMLW, C_WB, C_FETCH};
    int          en[6] = '{0, 0, 0, 0, 0, 1};
    applyStimulus();
    opcode = 4'b0010;
    memReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectorsApplied++;
      if (state !== 3'(es[i]) || ctrl !== ec[i] || instrCount !== 16'(en[i])) begin
        miscompares++;
        $display("[TB] FAIL mem_ready_ignored[%0d]: got state=%0d ctrl=%b count=%0d want state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instrCount, es[i], ec[i], en[i]);
      end
      @(negedge clock);
    end
    memReady = 1'b1;
  endtask
`endif

  // Run every scenario in order, then print the summary
  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_memory();
    test_illegal_halt();
    test_count_wrap();
    test_reset_in_mem();
    test_mem_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
